second_counter: RTL and testbench

- Parking-meter occupancy timer, clocked by the 1 Hz tick clock.
- Counts whole seconds a vehicle has been parked and presents the elapsed time as a binary count for the display/billing logic.
- Count restarts at each new parking session, holds after departure, and saturates instead of wrapping.

---
 rtl/parking_pkg.sv | 8 +
 rtl/rise_detect.sv | 24 ++
 rtl/second_counter.sv | 43 ++++
 tb/tb_second_counter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared parking-meter constants.
// Display, fee and timer blocks take their count width from here.
package parking_pkg;

    localparam int SEC_W   = 12;
    localparam int SEC_MAX = (1 << SEC_W) - 1;

endpackage

// File: rtl/rise_detect.sv
// Registered copy of a synchronous level plus its rising-edge pulse.
// Also used by the coin-input logic.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q    = r_q;
    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/second_counter.sv
// Parking occupancy timer: whole seconds parked, saturating,
// restarting on each new session and holding after departure.
module second_counter
    import parking_pkg::*;
#(
    parameter int WIDTH     = SEC_W,
    parameter int MAX_COUNT = SEC_MAX
) (
    input  logic             clk_1Hz,
    input  logic             rst,
    input  logic             parked,
    output logic [WIDTH-1:0] sec_count
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

    logic             w_parked_q;
    logic             w_start;
    logic [WIDTH-1:0] r_count;

    rise_detect u_rise (
        .clk    (clk_1Hz),
        .rst_n  (rst),
        .i_d    (parked),
        .o_q    (w_parked_q),
        .o_rise (w_start)
    );

    // The first parked second counts, so a session start loads 1.
    always_ff @(posedge clk_1Hz or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= LP_ONE;
        end else if (parked && w_parked_q && (r_count < LP_MAX)) begin
            r_count <= r_count + LP_ONE;
        end
    end

    assign sec_count = r_count;

endmodule

// File: tb/tb_second_counter.sv
// Directed bench for second_counter: a 12-bit instance and a
// 4-bit instance saturating at 15 share the same stimulus.
module tb_second_counter;

    typedef struct {
        bit    rst;
        bit    parked;
        int    e12;
        int    e4;
        string nm;
    } vec_t;

    vec_t        tbl[$];
    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        parked = 1'b0;
    logic [11:0] c12;
    logic [3:0]  c4;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    second_counter u12 (
        .clk_1Hz   (clk),
        .rst       (rst),
        .parked    (parked),
        .sec_count (c12)
    );

    second_counter #(
        .WIDTH     (4),
        .MAX_COUNT (15)
    ) u4 (
        .clk_1Hz   (clk),
        .rst       (rst),
        .parked    (parked),
        .sec_count (c4)
    );

    function automatic int mn(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_both(string nm, int e12, int e4);
        chk({nm, "/w12"}, {20'b0, c12}, e12);
        chk({nm, "/w4"}, {28'b0, c4}, e4);
    endtask

    task automatic add(bit r, bit p, int e12, int e4, string nm);
        vec_t v;
        v.rst    = r;
        v.parked = p;
        v.e12    = e12;
        v.e4     = e4;
        v.nm     = nm;
        tbl.push_back(v);
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst    = tbl[i].rst;
            parked = tbl[i].parked;
            @(posedge clk);
            #1;
            chk_both($sformatf("%s[%0d]", tbl[i].nm, i),
                     tbl[i].e12, tbl[i].e4);
        end
        tbl.delete();
    endtask

    initial begin
        #2;
        chk_both("rst_initial", 0, 0);

        // Phase A: reset, counting, hold, re-park, saturation.
        for (int i = 0; i < 10; i++)
            add(1'b0, 1'b0, 0, 0, "in_reset");
        add(1'b1, 1'b0, 0, 0, "post_reset");
        for (int i = 1; i <= 50; i++)
            add(1'b1, 1'b1, i, mn(i, 15), "count50");
        for (int i = 0; i < 50; i++)
            add(1'b1, 1'b0, 50, 15, "hold50");
        for (int i = 1; i <= 3; i++)
            add(1'b1, 1'b1, i, i, "repark");
        add(1'b1, 1'b0, 3, 3, "hold3");
        for (int i = 1; i <= 20; i++)
            add(1'b1, 1'b1, i, mn(i, 15), "sat20");
        add(1'b1, 1'b0, 20, 15, "hold_sat");
        for (int i = 1; i <= 7; i++)
            add(1'b1, 1'b1, i, i, "pre_rst");
        run_table();

        // Asynchronous reset between edges, parked still high.
        #2;
        rst = 1'b0;
        #1;
        chk_both("async_rst", 0, 0);
        @(posedge clk);
        #1;
        chk_both("rst_held", 0, 0);

        // Phase B: release with parked=1, then pulse patterns.
        add(1'b1, 1'b1, 1, 1, "release");
        add(1'b1, 1'b1, 2, 2, "release2");
        add(1'b1, 1'b0, 2, 2, "depart");
        add(1'b1, 1'b1, 1, 1, "pulse");
        add(1'b1, 1'b0, 1, 1, "pulse_hold");
        add(1'b1, 1'b0, 1, 1, "pulse_hold2");
        add(1'b1, 1'b1, 1, 1, "b2b_1");
        add(1'b1, 1'b0, 1, 1, "b2b_0");
        add(1'b1, 1'b1, 1, 1, "b2b_1b");
        add(1'b1, 1'b1, 2, 2, "b2b_cont");
        run_table();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
